// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-to-1 valid/ready stream multiplexer with a registered
// output stage. The arbitration mode is picked each cycle by 'mode':
//   mode=0  fixed select. The channel 'sel' is granted when it is valid.
//   mode=1  round-robin. The search starts one channel past the last
//           round-robin winner and wraps around.
// Optional build macro STREAM_MUX_RR_CNT_EN adds xfer_cnt, a saturating
// 16-bit count of output handshakes.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   mode, sel           arbitration mode and the fixed-select channel index
//   in_data/in_valid    packed channel data (ch i at [i*WIDTH +: WIDTH]) and valids
//   in_ready            per-channel ready (combinational)
//   out_data/out_ch     registered data and the index of its source channel
//   out_valid/out_ready registered output handshake
//   xfer_cnt            output handshake count (only with STREAM_MUX_RR_CNT_EN)
module stream_mux_rr #(
  parameter  int NUM_CH = 8,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef STREAM_MUX_RR_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            grant;
  logic [SEL_W-1:0]             gnt_idx;
  logic [SEL_W-1:0]             cand;
  logic                         gnt_any;
  logic                         load_en;
  logic                         hs_in;
  logic [SEL_W-1:0]             ptr;

  assign ch_data = in_data;

  // The output register can take a word when it is empty or draining now.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    gnt_any = 1'b0;
    if (!mode) begin
      // A sel value that names no real channel matches no loop index.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SEL_W'(i);
          gnt_any  = 1'b1;
        end
      end
    end else begin
      // The search visits ptr+1 .. ptr+NUM_CH. It ends at ptr itself, so a
      // lone requester can win again on the next cycle.
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = SEL_W'((int'(ptr) + k) % NUM_CH);
        if (!gnt_any && in_valid[cand]) begin
          grant[cand] = 1'b1;
          gnt_idx     = cand;
          gnt_any     = 1'b1;
        end
      end
    end
  end

  // Keep every ready low while reset is asserted.
  assign in_ready = (load_en && rst_n) ? grant : '0;
  assign hs_in    = gnt_any && load_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(NUM_CH - 1);
    end else if (hs_in) begin
      out_data  <= ch_data[gnt_idx];
      out_ch    <= gnt_idx;
      out_valid <= 1'b1;
      if (mode) ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (out_valid && out_ready && xfer_cnt != 16'hFFFF)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr. It runs directed scenarios and then random
// traffic. A behavioural reference model predicts in_ready and the output
// register every cycle.
module tb_stream_mux_rr;
  localparam int NUM_CH = 8;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
`ifdef STREAM_MUX_RR_CNT_EN
  logic [15:0]             xfer_cnt;
`endif

  logic [WIDTH-1:0] ch_d [NUM_CH];

  int checks = 0;
  int errors = 0;

  // Reference model state: the output word, the last round-robin winner,
  // and the handshake count.
  bit               m_v;
  logic [WIDTH-1:0] m_d;
  int               m_ch;
  int               m_ptr;
  int               m_cnt;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = ch_d[i];

  stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_MUX_RR_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the channel that the rules grant this cycle, or -1 for no grant.
  function automatic int m_grant();
    if (!rst_n) return -1;
    if (m_v && !out_ready) return -1;
    if (!mode) return (int'(sel) < NUM_CH && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Step one clock. Check ready before the edge and the outputs 1 time unit
  // after it.
  task automatic step();
    int g;
    #1;
    g = m_grant();
    chk("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (!rst_n) begin
      m_v = 0; m_d = '0; m_ch = 0; m_ptr = NUM_CH - 1; m_cnt = 0;
    end else begin
      if (m_v && out_ready && m_cnt != 16'hFFFF) m_cnt++;
      if (g >= 0) begin
        m_v = 1; m_d = ch_d[g]; m_ch = g;
        if (mode) m_ptr = g;
      end else if (out_ready) m_v = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data", 32'(out_data), 32'(m_d));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef STREAM_MUX_RR_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    int rr_seq [6];
    rr_seq = '{1, 4, 7, 1, 4, 7};
    m_v = 0; m_d = '0; m_ch = 0; m_ptr = NUM_CH - 1; m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) ch_d[i] = WIDTH'(8'h10 + i);

    // Reset with every channel requesting.
    rst_n = 0; mode = 1; sel = '0; in_valid = 8'hFF; out_ready = 1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);

    // Fixed select of ch3, then select an idle channel so the output drains.
    rst_n = 1; mode = 0; sel = 3; in_valid = 8'h08; ch_d[3] = 8'hA5;
    step();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch", 32'(out_ch), 32'd3);
    sel = 5;
    step();
    chk("fix_drain", 32'(out_valid), 32'h0);

    // Round-robin over channels 1, 4 and 7 at one word per cycle.
    mode = 1; in_valid = 8'b1001_0010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_ch", 32'(out_ch), 32'(rr_seq[k]));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure holds the word, then a drain and a load happen together.
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ch", 32'(out_ch), 32'd7);
      chk("bp_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1;
    step();
    chk("bp_reload", 32'(out_ch), 32'd1);

    // Reset while a word is stalled, then check the first RR grant.
    out_ready = 0;
    step();
    rst_n = 0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst_n = 1; in_valid = 8'b0011_0100; out_ready = 1;
    step();
    chk("post_rst_ch", 32'(out_ch), 32'd2);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SEL_W'($urandom_range(0, NUM_CH - 1));
      in_valid  = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) ch_d[i] = WIDTH'($urandom);
      step();
    end

`ifdef STREAM_MUX_RR_CNT_EN
    // Saturation of the handshake counter.
    rst_n = 1; mode = 1; in_valid = 8'hFF; out_ready = 1;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_hold", 32'(xfer_cnt), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
